// File: rtl/compressor_pkg.sv
// Shared constants and helpers for the multi-lane bit-plane compressor.
package compressor_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(value)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned DEF_SIZE_INPUT = 8;
    localparam int unsigned DEF_SIZE_CODE  = 5;
    localparam int unsigned DEF_NUM_LANES  = 4;
    localparam int unsigned LANE_CNT_W     = clog2(DEF_NUM_LANES + 1);

    // Saturation limits for the default counter width.
    localparam int UP_SAT_MAX  = (1 << DEF_SIZE_CODE) - 1;
    localparam int NEG_SAT_MIN = -(1 << (DEF_SIZE_CODE - 1));

endpackage

// File: rtl/compressor_multilane_if.sv
// Input lanes, control strobes and snapshot handshake of the multi-lane compressor.
interface compressor_multilane_if import compressor_pkg::*; #(
    parameter int unsigned SIZE_INPUT = DEF_SIZE_INPUT,
    parameter int unsigned SIZE_CODE  = DEF_SIZE_CODE,
    parameter int unsigned NUM_LANES  = DEF_NUM_LANES
);
    logic                            enable;
    logic                            clear;
    logic [NUM_LANES*SIZE_INPUT-1:0] numin;
    logic                            dump;
    logic                            dump_ready;
    logic                            out_valid;
    logic                            out_ready;
    logic [SIZE_INPUT*SIZE_CODE-1:0] countout;
    logic [SIZE_INPUT-1:0]           ovf_out;

    modport master (
        output enable, clear, numin, dump, out_ready,
        input  dump_ready, out_valid, countout, ovf_out
    );

    modport slave (
        input  enable, clear, numin, dump, out_ready,
        output dump_ready, out_valid, countout, ovf_out
    );

endinterface

// File: rtl/plane_counter.sv
// One bit plane: lane popcount into a saturating accumulator with a sticky overflow flag.
// NEG=1 makes it a signed down-counter for the two's-complement sign plane.
module plane_counter import compressor_pkg::*; #(
    parameter int unsigned SIZE_CODE = DEF_SIZE_CODE,
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter bit          NEG       = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 restart,
    input  logic [NUM_LANES-1:0] lane_bits,
    output logic [SIZE_CODE-1:0] snap_count,
    output logic                 snap_ovf
);

    localparam int unsigned CntW = clog2(NUM_LANES + 1);
    localparam int unsigned SumW = SIZE_CODE + 1;

    logic [CntW-1:0]      inc;
    logic [SumW-1:0]      sum;
    logic                 clip;
    logic [SIZE_CODE-1:0] sat;
    logic [SIZE_CODE-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    always_comb begin
        inc = '0;
        if (enable) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                inc = inc + CntW'(lane_bits[l]);
            end
        end
    end

    // One extra bit of headroom: clipping is detected before anything reaches state.
    always_comb begin
        if (NEG) begin
            sum  = {acc_q[SIZE_CODE-1], acc_q} - SumW'(inc);
            clip = sum[SumW-1] ^ sum[SumW-2];
            sat  = clip ? {1'b1, {(SIZE_CODE-1){1'b0}}} : sum[SIZE_CODE-1:0];
        end else begin
            sum  = {1'b0, acc_q} + SumW'(inc);
            clip = sum[SumW-1];
            sat  = clip ? '1 : sum[SIZE_CODE-1:0];
        end
    end

    assign snap_count = sat;
    assign snap_ovf   = ovf_q | clip;

    always_comb begin
        acc_d = sat;
        ovf_d = ovf_q | clip;
        if (clear || restart) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/compressor_multilane.sv
// Multi-lane bit-plane compressor: per-plane popcount accumulation with a valid/ready
// snapshot register that restarts accumulation on the same edge as a dump.
module compressor_multilane import compressor_pkg::*; #(
    parameter int unsigned SIZE_INPUT = DEF_SIZE_INPUT,
    parameter int unsigned SIZE_CODE  = DEF_SIZE_CODE,
    parameter int unsigned NUM_LANES  = DEF_NUM_LANES
) (
    input logic                    clk,
    input logic                    reset,
    compressor_multilane_if.slave  bus
);

    logic [SIZE_INPUT-1:0][NUM_LANES-1:0] plane_bits;
    logic [SIZE_INPUT*SIZE_CODE-1:0]      snap_count;
    logic [SIZE_INPUT-1:0]                snap_ovf;
    logic                                 dump_ready;
    logic                                 dump_accept;

    logic                            out_valid_q, out_valid_d;
    logic [SIZE_INPUT*SIZE_CODE-1:0] countout_q, countout_d;
    logic [SIZE_INPUT-1:0]           ovf_out_q, ovf_out_d;

    // Transpose lanes into bit planes.
    always_comb begin
        for (int i = 0; i < SIZE_INPUT; i++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                plane_bits[i][l] = bus.numin[l*SIZE_INPUT + i];
            end
        end
    end

    assign dump_ready  = !out_valid_q || bus.out_ready;
    assign dump_accept = bus.dump && dump_ready && !bus.clear;

    for (genvar i = 0; i < SIZE_INPUT; i++) begin : g_plane
        plane_counter #(
            .SIZE_CODE (SIZE_CODE),
            .NUM_LANES (NUM_LANES),
            .NEG       (i == SIZE_INPUT - 1)
        ) u_plane (
            .clk        (clk),
            .reset      (reset),
            .enable     (bus.enable),
            .clear      (bus.clear),
            .restart    (dump_accept),
            .lane_bits  (plane_bits[i]),
            .snap_count (snap_count[i*SIZE_CODE +: SIZE_CODE]),
            .snap_ovf   (snap_ovf[i])
        );
    end

    always_comb begin
        out_valid_d = out_valid_q;
        countout_d  = countout_q;
        ovf_out_d   = ovf_out_q;
        if (dump_accept) begin
            out_valid_d = 1'b1;
            countout_d  = snap_count;
            ovf_out_d   = snap_ovf;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            countout_q  <= '0;
            ovf_out_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            countout_q  <= countout_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

    assign bus.dump_ready = dump_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.countout   = countout_q;
    assign bus.ovf_out    = ovf_out_q;

endmodule

// File: tb/tb_compressor_multilane.sv
// Scoreboard bench for compressor_multilane: a behavioural plane model predicts each snapshot.
module tb_compressor_multilane;

    localparam int SI = 8;
    localparam int SC = 5;
    localparam int NL = 4;

    typedef struct {
        logic [SI*SC-1:0] cnt;
        logic [SI-1:0]    ovf;
    } snap_t;

    logic clk;
    logic reset;

    compressor_multilane_if #(.SIZE_INPUT(SI), .SIZE_CODE(SC), .NUM_LANES(NL)) bus ();

    compressor_multilane #(
        .SIZE_INPUT (SI),
        .SIZE_CODE  (SC),
        .NUM_LANES  (NL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_acc [SI];
    bit          m_ovf [SI];
    bit          m_valid;
    logic [SI*SC-1:0] m_held_cnt;
    logic [SI-1:0]    m_held_ovf;
    snap_t       sb [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SI; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_valid    = 1'b0;
        m_held_cnt = '0;
        m_held_ovf = '0;
        sb.delete();
    endtask

    function automatic logic [31:0] bc(input logic [7:0] w);
        return {NL{w}};
    endfunction

    task automatic step(input bit en, input logic [31:0] lanes, input bit dmp, input bit clr,
                        input bit rdy);
        bit    acc_dump;
        bit    clip;
        int    inc;
        int    nxt;
        snap_t s;
        bus.enable    = en;
        bus.numin     = lanes;
        bus.dump      = dmp;
        bus.clear     = clr;
        bus.out_ready = rdy;
        #1;
        check_eq("dump_ready", 64'(bus.dump_ready), 64'(!m_valid || rdy));
        @(posedge clk);
        acc_dump = dmp && (!m_valid || rdy) && !clr;
        s.cnt = '0;
        s.ovf = '0;
        for (int i = 0; i < SI; i++) begin
            inc = 0;
            if (en) begin
                for (int l = 0; l < NL; l++) inc += int'(lanes[l*SI + i]);
            end
            if (clr) begin
                m_acc[i] = 0;
                m_ovf[i] = 1'b0;
            end else begin
                if (i < SI - 1) begin
                    nxt  = m_acc[i] + inc;
                    clip = (nxt > 31);
                    if (clip) nxt = 31;
                end else begin
                    nxt  = m_acc[i] - inc;
                    clip = (nxt < -16);
                    if (clip) nxt = -16;
                end
                if (acc_dump) begin
                    s.cnt[i*SC +: SC] = 5'(nxt);
                    s.ovf[i]          = m_ovf[i] | clip;
                    m_acc[i]          = 0;
                    m_ovf[i]          = 1'b0;
                end else begin
                    m_acc[i] = nxt;
                    m_ovf[i] = m_ovf[i] | clip;
                end
            end
        end
        if (acc_dump) begin
            sb.push_back(s);
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (acc_dump) begin
            if (sb.size() == 0) begin
                check_eq("sb_empty", 64'(1), 64'(0));
            end else begin
                s = sb.pop_front();
                check_eq("countout", 64'(bus.countout), 64'(s.cnt));
                check_eq("ovf_out", 64'(bus.ovf_out), 64'(s.ovf));
                m_held_cnt = s.cnt;
                m_held_ovf = s.ovf;
            end
        end else if (m_valid) begin
            check_eq("held_cnt", 64'(bus.countout), 64'(m_held_cnt));
            check_eq("held_ovf", 64'(bus.ovf_out), 64'(m_held_ovf));
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.enable    = 1'b0;
        bus.clear     = 1'b0;
        bus.numin     = '0;
        bus.dump      = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        #12;
        check_eq("rst_valid", 64'(bus.out_valid), 64'(0));
        check_eq("rst_cnt", 64'(bus.countout), 64'(0));
        check_eq("rst_ovf", 64'(bus.ovf_out), 64'(0));
        check_eq("rst_dump_ready", 64'(bus.dump_ready), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;

        // 1: 3 cycles of 8'h01, dump on the third
        step(1, bc(8'h01), 0, 0, 1);
        step(1, bc(8'h01), 0, 0, 1);
        step(1, bc(8'h01), 1, 0, 1);
        check_eq("t1_plane0", 64'(bus.countout), 64'(12));
        check_eq("t1_ovf", 64'(bus.ovf_out), 64'(0));

        // 2: sign plane clips at -16
        for (int k = 0; k < 4; k++) step(1, bc(8'h80), 0, 0, 1);
        step(1, bc(8'h80), 1, 0, 1);
        check_eq("t2_plane7", 64'(bus.countout[7*SC +: SC]), 64'(5'b10000));
        check_eq("t2_ovf", 64'(bus.ovf_out), 64'(8'h80));

        // 3: up plane clips at 31, then an empty dump
        for (int k = 0; k < 7; k++) step(1, bc(8'h02), 0, 0, 1);
        step(1, bc(8'h02), 1, 0, 1);
        check_eq("t3_plane1", 64'(bus.countout[SC +: SC]), 64'(31));
        check_eq("t3_ovf", 64'(bus.ovf_out), 64'(8'h02));
        step(0, '0, 1, 0, 1);
        check_eq("t3_empty_cnt", 64'(bus.countout), 64'(0));
        check_eq("t3_empty_ovf", 64'(bus.ovf_out), 64'(0));

        // 4: backpressure holds the snapshot while accumulation continues
        step(1, bc(8'h01), 0, 0, 1);
        step(1, bc(8'h01), 0, 0, 1);
        step(1, bc(8'h01), 1, 0, 0);
        step(1, bc(8'h01), 0, 0, 0);
        step(1, bc(8'h01), 0, 0, 0);
        step(1, bc(8'h01), 1, 0, 0);
        check_eq("t4_stable", 64'(bus.countout), 64'(12));
        step(1, bc(8'h01), 0, 0, 0);
        step(1, bc(8'h01), 0, 0, 0);
        step(1, bc(8'h01), 1, 0, 1);
        check_eq("t4_plane0", 64'(bus.countout), 64'(24));

        // 5: clear wins over dump
        step(1, bc(8'h01), 0, 0, 1);
        step(1, bc(8'h01), 0, 0, 1);
        step(1, bc(8'h01), 1, 1, 1);
        check_eq("t5_no_snap", 64'(bus.countout), 64'(24));
        step(1, bc(8'h01), 0, 0, 1);
        step(1, bc(8'h01), 1, 0, 1);
        check_eq("t5_plane0", 64'(bus.countout), 64'(8));

        // 6: async reset with a held snapshot
        step(1, bc(8'h01), 0, 0, 1);
        step(1, bc(8'h01), 1, 0, 0);
        step(1, bc(8'h01), 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_valid", 64'(bus.out_valid), 64'(0));
        check_eq("t6_cnt", 64'(bus.countout), 64'(0));
        check_eq("t6_ovf", 64'(bus.ovf_out), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        step(1, bc(8'h01), 0, 0, 1);
        step(1, bc(8'h01), 1, 0, 1);
        check_eq("t6_plane0", 64'(bus.countout), 64'(8));

        // Mixed random traffic against the model
        for (int k = 0; k < 40; k++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0, ($urandom % 12) == 0,
                 ($urandom % 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
